// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit:
//   - estado_t : FSM state encoding (also exported on the debug port)
//   - OP_*     : supported major opcodes
//   - ALU_*    : ULA operation select codes
//   - branch helpers: which funct3 values are supported and whether taken
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_BUSCA = 3'd1,
        ST_DECOD = 3'd2,
        ST_EXEC  = 3'd3,
        ST_MEM   = 3'd4,
        ST_ESCR  = 3'd5,
        ST_ERRO  = 3'd6
    } estado_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // beq / bne / blt / bge are the only conditional branches supported.
    function automatic logic branch_valido(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Decision is taken from the ULA flags of rs1 - rs2 computed in EXEC.
    function automatic logic branch_taken(input logic [2:0] f3, input logic n, input logic z);
        logic t;
        t = 1'b0;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = n;
            3'b101:  t = ~n;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decod_ula.sv
// ----------------------------------------------------------------------------
// decod_ula
// Combinational ULA operation decoder.
// Ports:
//   i_opcode [6:0]  instruction opcode
//   i_funct3 [2:0]  instruction funct3
//   i_bit30         instruction bit 30 (selects SUB for R-type funct3=000)
//   o_alu_op [3:0]  ULA select code
//   o_valido        1 when opcode (and, for R/I, funct3) is supported
// ----------------------------------------------------------------------------
module decod_ula
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_bit30,
    output logic [3:0] o_alu_op,
    output logic       o_valido
);

    always_comb begin
        o_alu_op = ALU_ADD;
        o_valido = 1'b0;
        case (i_opcode)
            OP_R, OP_I: begin
                o_valido = 1'b1;
                case (i_funct3)
                    // bit30 only means SUB for register-register; addi has
                    // immediate bits there.
                    3'b000:  o_alu_op = ((i_opcode == OP_R) && i_bit30) ? ALU_SUB : ALU_ADD;
                    3'b111:  o_alu_op = ALU_AND;
                    3'b110:  o_alu_op = ALU_OR;
                    3'b100:  o_alu_op = ALU_XOR;
                    3'b001:  o_alu_op = ALU_SLL;
                    3'b101:  o_alu_op = ALU_SRL;
                    3'b010:  o_alu_op = ALU_SLT;
                    default: o_valido = 1'b0;
                endcase
            end
            OP_LW, OP_SW: begin
                o_valido = 1'b1;
                o_alu_op = ALU_ADD;
            end
            // Branch funct3 is checked later, in EXEC.
            OP_B: begin
                o_valido = 1'b1;
                o_alu_op = ALU_SUB;
            end
            default: begin
                o_valido = 1'b0;
                o_alu_op = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/unid_controle_multiciclo.sv
// ----------------------------------------------------------------------------
// unid_controle_multiciclo
// Multi-cycle control unit for the RV32I-subset datapath. Each instruction
// walks BUSCA -> DECOD -> EXEC [-> MEM] [-> ESCR] -> BUSCA; unsupported
// encodings park the FSM in ERRO until reset.
//
// Parameter: RESET_PC_HOLD (1..15) cycles spent in INIT after reset.
// Optional build macro: PERF_COUNT_EN enables the n_ciclos / n_inst counters;
// without it both ports are tied to 0.
//
// Ports:
//   clk, rst (sync, active high)
//   inst[31:0]   instruction from mem_inst (latched while ir_write=1)
//   n, z         ULA negative / zero flags
//   pc_write, ir_write, regWrite, ALUSrc, SeltipoSouB, MemToReg,
//   MemWrite, PCSrc, ALUOp[3:0]   datapath controls
//   estado[2:0]  current FSM state (debug)
//   ilegal       sticky illegal-instruction flag
//   n_ciclos, n_inst [31:0]  performance counters
//
// Control outputs are combinational from state and the latched instruction
// fields; they are forced to their idle values while rst is high so an
// aborted instruction never writes anything in the reset cycle.
// ----------------------------------------------------------------------------
module unid_controle_multiciclo
    import ctrl_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        n,
    input  logic        z,
    output logic        pc_write,
    output logic        ir_write,
    output logic        regWrite,
    output logic        ALUSrc,
    output logic        SeltipoSouB,
    output logic        MemToReg,
    output logic        MemWrite,
    output logic        PCSrc,
    output logic [3:0]  ALUOp,
    output logic [2:0]  estado,
    output logic        ilegal,
    output logic [31:0] n_ciclos,
    output logic [31:0] n_inst
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    estado_t    r_estado;
    estado_t    w_prox;
    logic [3:0] r_hold;
    logic       r_ilegal;
    logic       w_to_erro;

    // Only the fields the control unit decodes are kept.
    logic [6:0] r_opcode;
    logic [2:0] r_funct3;
    logic       r_bit30;

    logic [3:0] w_alu_op;
    logic       w_valido;

    // Remaining instruction bits belong to the datapath (registers, imm).
    logic       w_unused_inst;
    assign w_unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

    decod_ula u_decod_ula (
        .i_opcode (r_opcode),
        .i_funct3 (r_funct3),
        .i_bit30  (r_bit30),
        .o_alu_op (w_alu_op),
        .o_valido (w_valido)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= ST_INIT;
            r_hold   <= '0;
            r_ilegal <= 1'b0;
        end else begin
            r_estado <= w_prox;
            if (r_estado == ST_INIT) begin
                r_hold <= r_hold + 4'd1;
            end
            if (w_to_erro) begin
                r_ilegal <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ir_write) begin
            r_opcode <= inst[6:0];
            r_funct3 <= inst[14:12];
            r_bit30  <= inst[30];
        end
    end

    always_comb begin
        w_prox      = r_estado;
        w_to_erro   = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        regWrite    = 1'b0;
        ALUSrc      = 1'b0;
        SeltipoSouB = 1'b0;
        MemToReg    = 1'b0;
        MemWrite    = 1'b0;
        PCSrc       = 1'b0;
        ALUOp       = ALU_ADD;

        case (r_estado)
            ST_INIT: begin
                if (r_hold == HOLD_LAST) begin
                    w_prox = ST_BUSCA;
                end
            end
            ST_BUSCA: begin
                ir_write = 1'b1;
                w_prox   = ST_DECOD;
            end
            ST_DECOD: begin
                if (w_valido) begin
                    w_prox = ST_EXEC;
                end else begin
                    w_prox    = ST_ERRO;
                    w_to_erro = 1'b1;
                end
            end
            ST_EXEC: begin
                case (r_opcode)
                    OP_R: begin
                        ALUOp  = w_alu_op;
                        w_prox = ST_ESCR;
                    end
                    OP_I: begin
                        ALUSrc = 1'b1;
                        ALUOp  = w_alu_op;
                        w_prox = ST_ESCR;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc = 1'b1;
                        ALUOp  = ALU_ADD;
                        w_prox = ST_MEM;
                    end
                    OP_B: begin
                        if (branch_valido(r_funct3)) begin
                            ALUOp       = ALU_SUB;
                            SeltipoSouB = 1'b1;
                            pc_write    = 1'b1;
                            PCSrc       = branch_taken(r_funct3, n, z);
                            w_prox      = ST_BUSCA;
                        end else begin
                            w_prox    = ST_ERRO;
                            w_to_erro = 1'b1;
                        end
                    end
                    default: begin
                        w_prox    = ST_ERRO;
                        w_to_erro = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                // Address stays on the ULA output for the whole access.
                ALUSrc = 1'b1;
                ALUOp  = ALU_ADD;
                if (r_opcode == OP_SW) begin
                    MemWrite = 1'b1;
                    pc_write = 1'b1;
                    w_prox   = ST_BUSCA;
                end else begin
                    w_prox = ST_ESCR;
                end
            end
            ST_ESCR: begin
                regWrite = 1'b1;
                pc_write = 1'b1;
                MemToReg = (r_opcode == OP_LW);
                // Keep the ULA result stable while it is written back.
                ALUSrc   = (r_opcode != OP_R);
                ALUOp    = w_alu_op;
                w_prox   = ST_BUSCA;
            end
            default: begin
                w_prox = ST_ERRO;
            end
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            regWrite    = 1'b0;
            ALUSrc      = 1'b0;
            SeltipoSouB = 1'b0;
            MemToReg    = 1'b0;
            MemWrite    = 1'b0;
            PCSrc       = 1'b0;
            ALUOp       = ALU_ADD;
        end
    end

    assign estado = r_estado;
    assign ilegal = r_ilegal;

`ifdef PERF_COUNT_EN
    logic [31:0] r_n_ciclos;
    logic [31:0] r_n_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_ciclos <= '0;
            r_n_inst   <= '0;
        end else begin
            r_n_ciclos <= r_n_ciclos + 32'd1;
            if (pc_write) begin
                r_n_inst <= r_n_inst + 32'd1;
            end
        end
    end

    assign n_ciclos = r_n_ciclos;
    assign n_inst   = r_n_inst;
`else
    assign n_ciclos = '0;
    assign n_inst   = '0;
`endif

endmodule

// File: tb/tb_unid_controle_multiciclo.sv
// ----------------------------------------------------------------------------
// tb_unid_controle_multiciclo
// Directed bench for the multi-cycle control unit. For each instruction the
// model expands the instruction into the list of control words it must
// produce, one per cycle, and queues them; a compare process pops one word
// per cycle on the falling edge and also tracks the performance counters.
// Control word layout (16 bits):
//   [15:13] estado [12] ilegal [11] pc_write [10] ir_write [9] regWrite
//   [8] ALUSrc [7] SeltipoSouB [6] MemToReg [5] MemWrite [4] PCSrc [3:0] ALUOp
// ----------------------------------------------------------------------------
module tb_unid_controle_multiciclo;

`ifdef PERF_COUNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] M_R  = 7'b0110011;
    localparam logic [6:0] M_I  = 7'b0010011;
    localparam logic [6:0] M_LW = 7'b0000011;
    localparam logic [6:0] M_SW = 7'b0100011;
    localparam logic [6:0] M_B  = 7'b1100011;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        n;
    logic        z;
    logic        pc_write, ir_write, regWrite, ALUSrc, SeltipoSouB;
    logic        MemToReg, MemWrite, PCSrc, ilegal;
    logic [3:0]  ALUOp;
    logic [2:0]  estado;
    logic [31:0] n_ciclos, n_inst;

    always #5 clk = ~clk;

    unid_controle_multiciclo #(.RESET_PC_HOLD(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .n           (n),
        .z           (z),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .regWrite    (regWrite),
        .ALUSrc      (ALUSrc),
        .SeltipoSouB (SeltipoSouB),
        .MemToReg    (MemToReg),
        .MemWrite    (MemWrite),
        .PCSrc       (PCSrc),
        .ALUOp       (ALUOp),
        .estado      (estado),
        .ilegal      (ilegal),
        .n_ciclos    (n_ciclos),
        .n_inst      (n_inst)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    logic [15:0] m_w [0:5];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          armed = 1'b0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;

    // ---------------- model ----------------
    function automatic logic [15:0] word(input logic [2:0] st, input logic il,
                                         input logic [7:0] en, input logic [3:0] op);
        return {st, il, en, op};
    endfunction

    function automatic logic [3:0] model_alu(input logic [6:0] op, input logic [2:0] f3,
                                             input logic b30);
        logic [3:0] a;
        a = 4'd0;
        if (op == M_B) begin
            a = 4'd1;
        end else if (op == M_LW || op == M_SW) begin
            a = 4'd0;
        end else begin
            case (f3)
                3'b000:  a = (op == M_R && b30) ? 4'd1 : 4'd0;
                3'b111:  a = 4'd2;
                3'b110:  a = 4'd3;
                3'b100:  a = 4'd4;
                3'b001:  a = 4'd5;
                3'b101:  a = 4'd6;
                3'b010:  a = 4'd7;
                default: a = 4'd0;
            endcase
        end
        return a;
    endfunction

    // Expands one legal instruction into its per-cycle control words in m_w,
    // returns the number of cycles from BUSCA to the next BUSCA.
    function automatic int build(input logic [31:0] i, input logic nn, input logic zz);
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] a;
        logic       as;
        logic       tk;
        int         len;
        op = i[6:0];
        f3 = i[14:12];
        a  = model_alu(op, f3, i[30]);
        m_w[0] = word(3'd1, 1'b0, 8'b0100_0000, 4'd0);
        m_w[1] = word(3'd2, 1'b0, 8'b0000_0000, 4'd0);
        len = 2;
        if (op == M_R || op == M_I) begin
            as = (op == M_I);
            m_w[2] = word(3'd3, 1'b0, {3'b000, as, 4'b0000}, a);
            m_w[3] = word(3'd5, 1'b0, {3'b101, as, 4'b0000}, a);
            len = 4;
        end else if (op == M_LW) begin
            m_w[2] = word(3'd3, 1'b0, 8'b0001_0000, 4'd0);
            m_w[3] = word(3'd4, 1'b0, 8'b0001_0000, 4'd0);
            m_w[4] = word(3'd5, 1'b0, 8'b1011_0100, 4'd0);
            len = 5;
        end else if (op == M_SW) begin
            m_w[2] = word(3'd3, 1'b0, 8'b0001_0000, 4'd0);
            m_w[3] = word(3'd4, 1'b0, 8'b1001_0010, 4'd0);
            len = 4;
        end else if (op == M_B) begin
            case (f3)
                3'b000:  tk = zz;
                3'b001:  tk = !zz;
                3'b100:  tk = nn;
                default: tk = !nn;
            endcase
            m_w[2] = word(3'd3, 1'b0, {4'b1000, 1'b1, 2'b00, tk}, 4'd1);
            len = 3;
        end
        return len;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic run_inst(input logic [31:0] i, input logic nn, input logic zz);
        int len;
        inst = i;
        n    = nn;
        z    = zz;
        len  = build(i, nn, zz);
        for (int k = 0; k < len; k++) exp_q.push_back(m_w[k]);
        repeat (len) tick();
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [15:0] w;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL queue_empty at t=%0t", $time);
                end else begin
                    w   = exp_q.pop_front();
                    got = {estado, ilegal, pc_write, ir_write, regWrite, ALUSrc,
                           SeltipoSouB, MemToReg, MemWrite, PCSrc, ALUOp};
                    n_cmp++;
                    if (got !== w) begin
                        n_bad++;
                        $display("FAIL ctrl t=%0t got=%h exp=%h", $time, got, w);
                    end
                    n_cmp++;
                    if (n_ciclos !== (PERF ? m_cyc : 32'd0) ||
                        n_inst !== (PERF ? m_ret : 32'd0)) begin
                        n_bad++;
                        $display("FAIL perf t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                                 n_ciclos, n_inst, PERF ? m_cyc : 32'd0, PERF ? m_ret : 32'd0);
                    end
                    if (rst) begin
                        m_cyc = 32'd0;
                        m_ret = 32'd0;
                    end else begin
                        m_cyc = m_cyc + 32'd1;
                        m_ret = m_ret + {31'd0, w[11]};
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int len;
        rst  = 1'b1;
        inst = 32'd0;
        n    = 1'b0;
        z    = 1'b0;

        // Pin the model against hand-computed words.
        len = build(32'h00208093, 1'b0, 1'b0);
        check("model_addi_len", len, 4);
        check("model_busca", {16'd0, m_w[0]}, 32'h2400);
        check("model_addi_exec", {16'd0, m_w[2]}, 32'h6100);
        check("model_addi_escr", {16'd0, m_w[3]}, 32'hAB00);
        len = build(32'h40208033, 1'b0, 1'b0);
        check("model_sub_exec", {16'd0, m_w[2]}, 32'h6001);
        len = build(32'h0000A103, 1'b0, 1'b0);
        check("model_lw_len", len, 5);
        check("model_lw_escr", {16'd0, m_w[4]}, 32'hAB40);
        len = build(32'h0020A023, 1'b0, 1'b0);
        check("model_sw_len", len, 4);
        check("model_sw_mem", {16'd0, m_w[3]}, 32'h8920);
        len = build(32'h00208463, 1'b0, 1'b1);
        check("model_beq_len", len, 3);
        check("model_beq_taken", {16'd0, m_w[2]}, 32'h6891);
        len = build(32'h00208463, 1'b0, 1'b0);
        check("model_beq_not", {16'd0, m_w[2]}, 32'h6881);

        // Reset held two edges, then one INIT cycle.
        tick();
        exp_q.push_back(word(3'd0, 1'b0, 8'd0, 4'd0));
        armed = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back(word(3'd0, 1'b0, 8'd0, 4'd0));
        tick();

        // Three addi back to back from reset.
        repeat (3) run_inst(32'h00208093, 1'b0, 1'b0);
        check("perf_ciclos_3addi", n_ciclos, PERF ? 32'd13 : 32'd0);
        check("perf_inst_3addi", n_inst, PERF ? 32'd3 : 32'd0);

        run_inst(32'h40208033, 1'b0, 1'b0);  // sub
        run_inst(32'h0000A103, 1'b0, 1'b0);  // lw
        run_inst(32'h0020A023, 1'b0, 1'b0);  // sw
        run_inst(32'h00208463, 1'b0, 1'b1);  // beq taken
        run_inst(32'h00208463, 1'b0, 1'b0);  // beq not taken
        run_inst(32'h0020C463, 1'b1, 1'b0);  // blt taken
        run_inst(32'h0020C463, 1'b0, 1'b1);  // blt not taken
        run_inst(32'h00209463, 1'b0, 1'b0);  // bne taken
        run_inst(32'h0020D463, 1'b1, 1'b0);  // bge not taken
        run_inst(32'h002080B3, 1'b0, 1'b0);  // add
        run_inst(32'h0020F0B3, 1'b0, 1'b0);  // and
        run_inst(32'h0020E0B3, 1'b0, 1'b0);  // or
        run_inst(32'h0020C0B3, 1'b0, 1'b0);  // xor
        run_inst(32'h002090B3, 1'b0, 1'b0);  // sll
        run_inst(32'h0020D0B3, 1'b0, 1'b0);  // srl
        run_inst(32'h0020A0B3, 1'b0, 1'b0);  // slt
        run_inst(32'h0FF0F093, 1'b0, 1'b0);  // andi

        // Reset during ESCR of an addi: no enables in the reset cycle.
        inst = 32'h00208093;
        len  = build(inst, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) exp_q.push_back(m_w[k]);
        repeat (3) tick();
        rst = 1'b1;
        exp_q.push_back(word(3'd5, 1'b0, 8'd0, 4'd0));
        tick();
        rst = 1'b0;
        exp_q.push_back(word(3'd0, 1'b0, 8'd0, 4'd0));
        tick();

        // Illegal opcode: ERRO is absorbing with ilegal=1 until reset.
        inst = 32'h0000007F;
        exp_q.push_back(word(3'd1, 1'b0, 8'b0100_0000, 4'd0));
        exp_q.push_back(word(3'd2, 1'b0, 8'd0, 4'd0));
        repeat (2) tick();
        for (int k = 0; k < 10; k++) exp_q.push_back(word(3'd6, 1'b1, 8'd0, 4'd0));
        repeat (10) tick();
        rst = 1'b1;
        exp_q.push_back(word(3'd6, 1'b1, 8'd0, 4'd0));
        tick();
        rst = 1'b0;
        exp_q.push_back(word(3'd0, 1'b0, 8'd0, 4'd0));
        tick();
        run_inst(32'h00208093, 1'b0, 1'b0);

        armed = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog: the directed run is a few hundred cycles.
    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
